// File: rtl/hpdcache_decoder_pkg.sv
// Shared types and the index-to-mask decode rule for the registered mask decoder.
package hpdcache_decoder_pkg;

  typedef enum logic [1:0] {
    ONEHOT = 2'd0,
    THERMO = 2'd1,
    RANGE  = 2'd2
  } dec_mode_e;

  // Widest mask the decode function can produce; callers slice their OUT_W bits.
  localparam int unsigned MAX_OUT_W = 64;

  // Returns {err, mask}. Any error forces the mask to zero (no saturation).
  function automatic logic [MAX_OUT_W:0] decode_mask(input logic [31:0] idx,
                                                     input logic [31:0] lo,
                                                     input dec_mode_e   mode,
                                                     input logic [31:0] out_w);
    logic [MAX_OUT_W-1:0] mask;
    logic                 err;
    logic [31:0]          i_ext;
    mask = '0;
    err  = (idx >= out_w) || ((mode == RANGE) && ((lo >= out_w) || (lo > idx)));
    for (int unsigned i = 0; i < MAX_OUT_W; i++) begin
      i_ext = i;
      if (i_ext < out_w) begin
        case (mode)
          ONEHOT:  mask[i] = (idx == i_ext);
          THERMO:  mask[i] = (i_ext <= idx);
          RANGE:   mask[i] = (lo <= i_ext) && (i_ext <= idx);
          default: mask[i] = 1'b0;
        endcase
      end
    end
    if (err) mask = '0;
    return {err, mask};
  endfunction

endpackage

// File: rtl/hpdcache_decoder_core.sv
// Purely combinational index decode: one-hot, thermometer or range mask plus error flag.
module hpdcache_decoder_core
  import hpdcache_decoder_pkg::*;
#(
  parameter int unsigned N     = 3,
  parameter int unsigned OUT_W = 8,
  parameter int unsigned MODE  = 0
) (
  input  logic [N-1:0]     idx_i,
  input  logic [N-1:0]     lo_i,
  output logic [OUT_W-1:0] mask_o,
  output logic             err_o
);

  localparam dec_mode_e MODE_E = dec_mode_e'(MODE[1:0]);

  logic [MAX_OUT_W:0] res;

  assign res    = decode_mask(32'(idx_i), 32'(lo_i), MODE_E, OUT_W);
  assign mask_o = res[OUT_W-1:0];
  assign err_o  = res[MAX_OUT_W];

  if (OUT_W < MAX_OUT_W) begin : g_spare
    logic unused_spare;
    assign unused_spare = ^res[MAX_OUT_W-1:OUT_W];
  end

endmodule

// File: rtl/hpdcache_decoder_pipe.sv
// Registered, valid/ready index decoder with a 2-entry skid buffer (output reg + skid reg).
module hpdcache_decoder_pipe
  import hpdcache_decoder_pkg::*;
#(
  parameter int unsigned N     = 3,
  parameter int unsigned OUT_W = 8,
  parameter int unsigned MODE  = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [N-1:0]     in_idx_i,
  input  logic [N-1:0]     in_lo_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [OUT_W-1:0] out_mask_o,
  output logic             out_err_o
);

  if (N < 1 || N > 31) begin : g_bad_n
    $error("hpdcache_decoder_pipe: N must be in 1..31");
  end
  if (OUT_W < 1 || OUT_W > MAX_OUT_W || 64'(OUT_W) > (64'd1 << N)) begin : g_bad_out_w
    $error("hpdcache_decoder_pipe: OUT_W must be in 1..2**N (and <= MAX_OUT_W)");
  end
  if (MODE > 32'(RANGE)) begin : g_bad_mode
    $error("hpdcache_decoder_pipe: MODE must be 0, 1 or 2");
  end

  logic [OUT_W-1:0] dec_mask;
  logic             dec_err;

  hpdcache_decoder_core #(
    .N    (N),
    .OUT_W(OUT_W),
    .MODE (MODE)
  ) u_core (
    .idx_i (in_idx_i),
    .lo_i  (in_lo_i),
    .mask_o(dec_mask),
    .err_o (dec_err)
  );

  logic             or_valid_q, or_valid_d, or_err_q, or_err_d;
  logic [OUT_W-1:0] or_mask_q, or_mask_d;
  logic             sr_valid_q, sr_valid_d, sr_err_q, sr_err_d;
  logic [OUT_W-1:0] sr_mask_q, sr_mask_d;
  logic             ready_q, ready_d;
  logic             acc, pop;

  assign acc = in_valid_i & ready_q;
  assign pop = or_valid_q & out_ready_i;

  always_comb begin
    or_valid_d = or_valid_q;
    or_mask_d  = or_mask_q;
    or_err_d   = or_err_q;
    sr_valid_d = sr_valid_q;
    sr_mask_d  = sr_mask_q;
    sr_err_d   = sr_err_q;
    if (!or_valid_q || (pop && !sr_valid_q)) begin
      or_valid_d = acc;
      if (acc) begin
        or_mask_d = dec_mask;
        or_err_d  = dec_err;
      end
    end else if (pop) begin
      // Skid entry moves forward; a new beat can only arrive here if SR was empty.
      or_valid_d = 1'b1;
      or_mask_d  = sr_mask_q;
      or_err_d   = sr_err_q;
      sr_valid_d = acc;
      if (acc) begin
        sr_mask_d = dec_mask;
        sr_err_d  = dec_err;
      end
    end else if (acc) begin
      sr_valid_d = 1'b1;
      sr_mask_d  = dec_mask;
      sr_err_d   = dec_err;
    end
    if (flush_i) begin
      or_valid_d = 1'b0;
      sr_valid_d = 1'b0;
    end
    ready_d = ~sr_valid_d;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      or_valid_q <= 1'b0;
      or_mask_q  <= '0;
      or_err_q   <= 1'b0;
      sr_valid_q <= 1'b0;
      sr_mask_q  <= '0;
      sr_err_q   <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      or_valid_q <= or_valid_d;
      or_mask_q  <= or_mask_d;
      or_err_q   <= or_err_d;
      sr_valid_q <= sr_valid_d;
      sr_mask_q  <= sr_mask_d;
      sr_err_q   <= sr_err_d;
      ready_q    <= ready_d;
    end
  end

  assign in_ready_o  = ready_q;
  assign out_valid_o = or_valid_q;
  assign out_mask_o  = or_mask_q;
  assign out_err_o   = or_err_q;

endmodule

// File: tb/tb_hpdcache_decoder_pipe.sv
// Bench: three decoder instances (ONEHOT/THERMO/RANGE, N=3, OUT_W=6) against a queue reference model.
module tb_hpdcache_decoder_pipe;

  typedef struct {
    int idx;
    int lo;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [2:0] in_idx = '0;
  logic [2:0] in_lo = '0;
  logic [2:0] in_ready, out_valid, out_err;
  logic [5:0] out_mask [3];

  int    errors = 0;
  int    checks = 0;
  beat_t q[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    hpdcache_decoder_pipe #(.N(3), .OUT_W(6), .MODE(g)) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .flush_i    (flush),
      .in_valid_i (in_valid),
      .in_ready_o (in_ready[g]),
      .in_idx_i   (in_idx),
      .in_lo_i    (in_lo),
      .out_valid_o(out_valid[g]),
      .out_ready_i(out_ready),
      .out_mask_o (out_mask[g]),
      .out_err_o  (out_err[g])
    );
  end

  // Reference decode from the mask rules with plain integer arithmetic: {err, mask}.
  function automatic logic [6:0] ref_decode(int m, int idx, int lo);
    if (idx >= 6 || (m == 2 && (lo >= 6 || lo > idx))) return {1'b1, 6'd0};
    case (m)
      0:       return {1'b0, 6'(1 << idx)};
      1:       return {1'b0, 6'((1 << (idx + 1)) - 1)};
      default: return {1'b0, 6'(((1 << (idx + 1)) - 1) - ((1 << lo) - 1))};
    endcase
  endfunction

  // Drive one cycle of inputs (just after a negedge), advance the model at the posedge,
  // and return just after the following negedge so outputs can be sampled.
  task automatic drive_cycle(input bit v, input int idx, input int lo, input bit ordy,
                             input bit fl, input bit rst);
    beat_t b;
    bit    acc, pop;
    in_valid  = v;
    in_idx    = idx[2:0];
    in_lo     = lo[2:0];
    out_ready = ordy;
    flush     = fl;
    rst_n     = ~rst;
    b.idx = idx;
    b.lo  = lo;
    acc = v && (q.size() < 2);
    pop = ordy && (q.size() > 0);
    @(posedge clk);
    if (rst || fl) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(b);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive_cycle(0, 0, 0, 0, 0, 1);
    drive_cycle(0, 0, 0, 0, 0, 1);
    for (int m = 0; m < 3; m++) begin
      checks++;
      if (out_valid[m] !== 1'b0 || out_mask[m] !== 6'd0 || out_err[m] !== 1'b0 ||
          in_ready[m] !== 1'b1) begin
        errors++;
        $display("FAIL reset inst%0d: valid=%b mask=%b err=%b ready=%b, required 0 000000 0 1",
                 m, out_valid[m], out_mask[m], out_err[m], in_ready[m]);
      end
    end
  endtask

  task automatic test_decode();
    int         t_idx[6] = '{5, 6, 2, 7, 4, 1};
    int         t_lo[6]  = '{0, 0, 0, 0, 1, 4};
    logic [6:0] t_exp[6][3] = '{
      '{7'b0100000, 7'b0111111, 7'b0111111},
      '{7'b1000000, 7'b1000000, 7'b1000000},
      '{7'b0000100, 7'b0000111, 7'b0000111},
      '{7'b1000000, 7'b1000000, 7'b1000000},
      '{7'b0010000, 7'b0011111, 7'b0011110},
      '{7'b0000010, 7'b0000011, 7'b1000000}};
    drive_cycle(0, 0, 0, 1, 0, 0);
    for (int k = 0; k < 6; k++) begin
      drive_cycle(1, t_idx[k], t_lo[k], 1, 0, 0);
      for (int m = 0; m < 3; m++) begin
        checks++;
        if (out_valid[m] !== 1'b1 || {out_err[m], out_mask[m]} !== t_exp[k][m]) begin
          errors++;
          $display("FAIL decode inst%0d idx=%0d lo=%0d: valid=%b {err,mask}=%b, required 1 %b",
                   m, t_idx[k], t_lo[k], out_valid[m], {out_err[m], out_mask[m]}, t_exp[k][m]);
        end
      end
    end
    drive_cycle(0, 0, 0, 1, 0, 0);
    for (int m = 0; m < 3; m++) begin
      checks++;
      if (out_valid[m] !== 1'b0) begin
        errors++;
        $display("FAIL decode_drain inst%0d: valid=%b, required 0", m, out_valid[m]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_seq[4] = '{6'b000001, 6'b000010, 6'b000100, 6'b001000};
    logic [5:0] got[$];
    logic [5:0] pre_mask[3];
    int         sent = 0;
    bit         saw_ready_low = 0;
    for (int c = 0; c < 20 && got.size() < 4; c++) begin
      bit ordy, v, acc, pop, stall;
      ordy  = !(c == 2 || c == 3);
      v     = (sent < 4);
      acc   = v && (q.size() < 2);
      pop   = ordy && (q.size() > 0);
      stall = (q.size() > 0) && !ordy;
      if (pop) got.push_back(out_mask[0]);
      for (int m = 0; m < 3; m++) pre_mask[m] = out_mask[m];
      drive_cycle(v, sent, 0, ordy, 0, 0);
      if (acc) sent++;
      if (in_ready[0] === 1'b0) saw_ready_low = 1;
      for (int m = 0; m < 3; m++) begin
        checks++;
        if (in_ready[m] !== (q.size() < 2) || out_valid[m] !== (q.size() > 0)) begin
          errors++;
          $display("FAIL b2b_flow inst%0d cyc%0d: ready=%b valid=%b, required %b %b",
                   m, c, in_ready[m], out_valid[m], q.size() < 2, q.size() > 0);
        end
        if (stall) begin
          checks++;
          if (out_mask[m] !== pre_mask[m]) begin
            errors++;
            $display("FAIL b2b_stable inst%0d cyc%0d: mask=%b, required %b",
                     m, c, out_mask[m], pre_mask[m]);
          end
        end
      end
    end
    checks++;
    if (!saw_ready_low) begin
      errors++;
      $display("FAIL b2b_ready_drop: in_ready never 0, required 0 with two beats held");
    end
    checks++;
    if (got.size() != 4) begin
      errors++;
      $display("FAIL b2b_count: %0d beats emitted within budget, required 4", got.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (got[k] !== exp_seq[k]) begin
          errors++;
          $display("FAIL b2b_order beat%0d: mask=%b, required %b", k, got[k], exp_seq[k]);
        end
      end
    end
  endtask

  task automatic test_flush();
    drive_cycle(1, 3, 0, 0, 0, 0);
    drive_cycle(1, 4, 0, 0, 0, 0);
    checks++;
    if (in_ready[0] !== 1'b0 || out_valid[0] !== 1'b1) begin
      errors++;
      $display("FAIL flush_fill: ready=%b valid=%b, required 0 1", in_ready[0], out_valid[0]);
    end
    drive_cycle(1, 5, 0, 0, 1, 0);
    for (int m = 0; m < 3; m++) begin
      checks++;
      if (out_valid[m] !== 1'b0 || in_ready[m] !== 1'b1) begin
        errors++;
        $display("FAIL flush_full inst%0d: valid=%b ready=%b, required 0 1",
                 m, out_valid[m], in_ready[m]);
      end
    end
    // One beat held with ready high: the beat offered alongside the flush is dropped too.
    drive_cycle(1, 2, 0, 0, 0, 0);
    drive_cycle(1, 1, 0, 0, 1, 0);
    for (int c = 0; c < 4; c++) begin
      drive_cycle(0, 0, 0, 1, 0, 0);
      for (int m = 0; m < 3; m++) begin
        checks++;
        if (out_valid[m] !== 1'b0) begin
          errors++;
          $display("FAIL flush_stale inst%0d cyc%0d: valid=%b mask=%b, required valid 0",
                   m, c, out_valid[m], out_mask[m]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0] exp;
    drive_cycle(1, 2, 0, 0, 0, 0);
    drive_cycle(1, 5, 1, 0, 0, 0);
    drive_cycle(1, 4, 0, 0, 0, 1);
    for (int m = 0; m < 3; m++) begin
      checks++;
      if (out_valid[m] !== 1'b0 || out_mask[m] !== 6'd0 || out_err[m] !== 1'b0 ||
          in_ready[m] !== 1'b1) begin
        errors++;
        $display("FAIL reset_mid inst%0d: valid=%b mask=%b err=%b ready=%b, required 0 000000 0 1",
                 m, out_valid[m], out_mask[m], out_err[m], in_ready[m]);
      end
    end
    drive_cycle(1, 3, 1, 1, 0, 0);
    for (int m = 0; m < 3; m++) begin
      exp = ref_decode(m, 3, 1);
      checks++;
      if (out_valid[m] !== 1'b1 || {out_err[m], out_mask[m]} !== exp) begin
        errors++;
        $display("FAIL post_reset_latency inst%0d: valid=%b {err,mask}=%b, required 1 %b",
                 m, out_valid[m], {out_err[m], out_mask[m]}, exp);
      end
    end
    drive_cycle(0, 0, 0, 1, 0, 0);
  endtask

  task automatic test_random();
    logic [5:0] pre_mask[3];
    logic [6:0] exp;
    for (int c = 0; c < 400; c++) begin
      bit v, ordy, fl, stall;
      int idx, lo;
      v     = ($urandom_range(0, 3) != 0);
      ordy  = ($urandom_range(0, 2) != 0);
      fl    = ($urandom_range(0, 29) == 0);
      idx   = int'($urandom_range(0, 7));
      lo    = int'($urandom_range(0, 7));
      stall = (q.size() > 0) && !ordy && !fl;
      for (int m = 0; m < 3; m++) pre_mask[m] = out_mask[m];
      drive_cycle(v, idx, lo, ordy, fl, 0);
      for (int m = 0; m < 3; m++) begin
        checks++;
        if (in_ready[m] !== (q.size() < 2) || out_valid[m] !== (q.size() > 0)) begin
          errors++;
          $display("FAIL rand_flow inst%0d cyc%0d: ready=%b valid=%b, required %b %b",
                   m, c, in_ready[m], out_valid[m], q.size() < 2, q.size() > 0);
        end else if (q.size() > 0) begin
          exp = ref_decode(m, q[0].idx, q[0].lo);
          checks++;
          if ({out_err[m], out_mask[m]} !== exp) begin
            errors++;
            $display("FAIL rand_data inst%0d cyc%0d: {err,mask}=%b, required %b",
                     m, c, {out_err[m], out_mask[m]}, exp);
          end
          if (stall) begin
            checks++;
            if (out_mask[m] !== pre_mask[m]) begin
              errors++;
              $display("FAIL rand_stable inst%0d cyc%0d: mask=%b, required %b",
                       m, c, out_mask[m], pre_mask[m]);
            end
          end
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_decode();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
